branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences branch/jump resolution for the RV32I core.
- Accepts one control-transfer op per handshake from decode and registers it into a single EX slot.
- Evaluates the six B-type conditions plus JAL/JALR, then compares the outcome with the fetch prediction.
- On mismatch, issues a one-cycle PC redirect and holds an IF/ID flush window; the prediction table is optional.

Parameters:
- XLEN, 32, datapath width.
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (1..15).
- BHT_ENTRIES, 64, prediction table depth (power of 2); used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode presents a control-transfer op
- id_ready  out  1  block can accept an op this cycle
- id_is_br  in  1  B-type op
- id_is_jal  in  1  JAL
- id_is_jalr  in  1  JALR
- id_funct3  in  3  branch condition select
- id_pc  in  XLEN  op PC
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_dat  in  XLEN  forwarded rs1 value
- id_rs2_dat  in  XLEN  forwarded rs2 value
- id_pred_taken  in  1  prediction carried down from fetch
- ex_stall  in  1  back-end stall; freeze the EX slot
- redirect_valid  out  1  one-cycle pulse: fetch must jump
- redirect_pc  out  XLEN  correct next PC
- flush  out  1  kill IF/ID contents
- illegal_br  out  1  one-cycle pulse for B-type funct3 010/011
- ifu_pc  in  XLEN  fetch PC for lookup
- ifu_pred_taken  out  1  prediction for ifu_pc

Behaviour:
- States: IDLE (slot empty), EXEC (slot full), FLUSH.
- Reset is async. All outputs go to 0, the state to IDLE and the slot to invalid; all BHT counters go to 01 (weakly not-taken).
- Handshake:
  - id_ready = (state==IDLE) || (state==EXEC && !ex_stall).
  - An op is captured when id_valid && id_ready.
- Resolve timing: the resolve happens in the EX cycle when !ex_stall, so latency is 1 cycle from capture to redirect_valid.
  - With ex_stall high, the slot and all outputs hold, and no resolve occurs.
- funct3 conditions:
  - 000 eq, 001 ne.
  - 100 lt signed, 101 ge signed.
  - 110 ltu unsigned, 111 geu unsigned.
  - 010/011: illegal_br pulses, treated as not-taken.
- Taken outcome and target:
  - JAL: always taken, target = pc+imm.
  - JALR: always taken, target = (rs1+imm) & ~1.
  - B-type: target = pc+imm.
  - All adds are modulo 2^XLEN (wrap-around ignored).
- Redirect:
  - Mismatch when actual_taken != id_pred_taken, or for JALR always (target unknown to fetch).
  - Redirect PC: actual-taken → target, else pc+4.
  - redirect_valid pulses for 1 cycle; flush rises in the same cycle; the state goes to FLUSH.
- FLUSH:
  - A counter loads FLUSH_CYCLES-1 and flush stays high for FLUSH_CYCLES total cycles.
  - id_ready = 0 and captures are ignored.
  - Exit to IDLE.
- No mismatch: no pulse. Next state is EXEC if a new op is captured in the same cycle, else IDLE (back-to-back throughput 1/cycle).
- Reset mid-FLUSH or mid-EXEC: all state is dropped immediately, with no redirect.
- An id_valid with no type bit set is a protocol violation; it is accepted and resolves as not-taken.

Optional Feature:
BRANCH_BHT_EN:
- Defined:
  - Table of BHT_ENTRIES 2-bit saturating counters, indexed by pc[log2(BHT_ENTRIES)+1:2].
  - ifu_pred_taken = counter[ifu_pc index][1], combinational.
  - On every resolve of a B-type op (not JAL/JALR, not illegal), the counter increments if taken, else decrements, saturating at 00/11; the write happens at the resolve clock edge.
- Not defined:
  - No table.
  - ifu_pred_taken is tied to 0 and id_pred_taken is internally forced to 0, i.e. predict-not-taken; every taken op redirects.

Test Plan:
- Taken branch, default config:
  - Stimulus: BEQ with rs1=rs2=5, pc=0x100, imm=0x20, pred=0.
  - Response: next cycle redirect_valid=1, redirect_pc=0x120; flush high for 2 cycles; id_ready=0 for those 2 cycles.
- Signed vs unsigned compare, rs1=0xFFFFFFFF, rs2=1:
  - BLT: taken.
  - BLTU: not taken (pred=0, no redirect).
  - BGEU: taken.
- JALR target and wrap-around:
  - JALR with rs1=0x2003, imm=0 → redirect_pc=0x2002.
  - JAL pc=0xFFFFFFF0, imm=0x20 → redirect_pc=0x10.
- Back-to-back ops with a stall:
  - Two consecutive not-taken BNE ops (rs1=rs2) are accepted on consecutive cycles with no redirect.
  - Holding ex_stall=1 for 3 cycles keeps id_ready=0 and the outputs frozen.
- Illegal funct3 and reset mid-flush:
  - funct3=010 → illegal_br pulses, no redirect.
  - Assert rst_n=0 during FLUSH → flush=0 immediately and state IDLE.
- BRANCH_BHT_EN, pc=0x40:
  - Resolve taken twice → ifu_pred_taken for ifu_pc=0x40 goes 0→1 after the first resolve (01→10) and stays 1 (11).
  - A third op at that pc with pred=1 and taken → no redirect.

Source files
------------

// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decode handshake, EX stall, redirect/flush and fetch
// prediction lookup signals for branch_resolve_ctrl.
//
// Handshake: an op moves from decode into the EX slot on a rising clk edge
// where id_valid && id_ready are both high. id_valid is held with stable
// op fields until that edge. id_ready depends only on controller state and
// ex_stall, never on id_valid.
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic            id_is_br;
    logic            id_is_jal;
    logic            id_is_jalr;
    logic [2:0]      id_funct3;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rs1_dat;
    logic [XLEN-1:0] id_rs2_dat;
    logic            id_pred_taken;
    logic            ex_stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            illegal_br;
    logic [XLEN-1:0] ifu_pc;
    logic            ifu_pred_taken;

    // Decode/pipeline side: drives ops, stall and fetch PC.
    modport master (
        output id_valid, id_is_br, id_is_jal, id_is_jalr, id_funct3,
               id_pc, id_imm, id_rs1_dat, id_rs2_dat, id_pred_taken,
               ex_stall, ifu_pc,
        input  id_ready, redirect_valid, redirect_pc, flush, illegal_br,
               ifu_pred_taken
    );

    // Branch resolve controller side.
    modport slave (
        input  id_valid, id_is_br, id_is_jal, id_is_jalr, id_funct3,
               id_pc, id_imm, id_rs1_dat, id_rs2_dat, id_pred_taken,
               ex_stall, ifu_pc,
        output id_ready, redirect_valid, redirect_pc, flush, illegal_br,
               ifu_pred_taken
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: single-slot EX stage that resolves RV32I branches,
// JAL and JALR, compares against the fetch prediction and issues a
// one-cycle redirect followed by an IF/ID flush window.
// Optional feature macro: BRANCH_BHT_EN (2-bit saturating counter table).
// Without it, fetch predicts not-taken and every taken op redirects.
// o_dbg_state exposes the FSM encoding: 0 IDLE, 1 EXEC, 2 FLUSH.
module branch_resolve_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int BHT_ENTRIES  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolve_if.slave  bus,
    output logic [1:0]       o_dbg_state
);

    localparam logic [3:0] FLUSH_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // EX slot contents
    logic            r_is_br;
    logic            r_is_jal;
    logic            r_is_jalr;
    logic            r_pred;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;

    logic [3:0]      r_flush_cnt;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_illegal;

    logic            w_ready;
    logic            w_capture;
    logic            w_load;
    logic            w_resolve;
    logic            w_cond;
    logic            w_illegal;
    logic            w_taken;
    logic            w_mismatch;
    logic            w_id_pred;
    logic [XLEN-1:0] w_pc_imm;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redir_pc;

    assign w_capture = bus.id_valid && w_ready;
    assign w_resolve = (r_state == S_EXEC) && !bus.ex_stall;

    // Branch condition evaluation for the op held in the EX slot.
    always_comb begin
        w_cond    = 1'b0;
        w_illegal = 1'b0;
        case (r_funct3)
            3'b000:  w_cond = (r_rs1 == r_rs2);
            3'b001:  w_cond = (r_rs1 != r_rs2);
            3'b100:  w_cond = ($signed(r_rs1) <  $signed(r_rs2));
            3'b101:  w_cond = ($signed(r_rs1) >= $signed(r_rs2));
            3'b110:  w_cond = (r_rs1 <  r_rs2);
            3'b111:  w_cond = (r_rs1 >= r_rs2);
            default: w_illegal = r_is_br;  // 010/011 resolve as not-taken
        endcase
    end

    // Target arithmetic; all sums wrap modulo 2^XLEN.
    assign w_pc_imm   = r_pc + r_imm;
    assign w_jalr_tgt = (r_rs1 + r_imm) & ~(XLEN'(1));
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_target   = r_is_jalr ? w_jalr_tgt : w_pc_imm;

    // An op with no type bit set falls through to not-taken.
    assign w_taken    = r_is_jal || r_is_jalr || (r_is_br && w_cond);
    // Fetch never knows a JALR target, so JALR always redirects.
    assign w_mismatch = (w_taken != r_pred) || r_is_jalr;
    assign w_redir_pc = w_taken ? w_target : w_pc_plus4;

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.id_valid) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_ready = !bus.ex_stall;
                if (!bus.ex_stall) begin
                    if (w_mismatch) begin
                        w_state_nxt = S_FLUSH;
                    end else if (bus.id_valid) begin
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (r_flush_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An op handed over in the same cycle as a mispredict is wrong-path
    // work sitting in ID; it completes the handshake but is discarded.
    assign w_load = w_capture && (w_state_nxt == S_EXEC);

    // State register and flush window counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_resolve && w_mismatch) begin
                r_flush_cnt <= FLUSH_CNT_INIT;
            end else if ((r_state == S_FLUSH) && (r_flush_cnt != 4'd0)) begin
                r_flush_cnt <= r_flush_cnt - 4'd1;
            end
        end
    end

    // EX slot capture; the slot holds while ex_stall keeps id_ready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_br   <= 1'b0;
            r_is_jal  <= 1'b0;
            r_is_jalr <= 1'b0;
            r_pred    <= 1'b0;
            r_funct3  <= 3'd0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
        end else if (w_load) begin
            r_is_br   <= bus.id_is_br;
            r_is_jal  <= bus.id_is_jal;
            r_is_jalr <= bus.id_is_jalr;
            r_pred    <= w_id_pred;
            r_funct3  <= bus.id_funct3;
            r_pc      <= bus.id_pc;
            r_imm     <= bus.id_imm;
            r_rs1     <= bus.id_rs1_dat;
            r_rs2     <= bus.id_rs2_dat;
        end
    end

    // Resolve outputs: pulses last one cycle, redirect_pc holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_illegal        <= 1'b0;
        end else begin
            r_redirect_valid <= w_resolve && w_mismatch;
            r_illegal        <= w_resolve && w_illegal;
            if (w_resolve && w_mismatch) begin
                r_redirect_pc <= w_redir_pc;
            end
        end
    end

`ifdef BRANCH_BHT_EN
    localparam int BHT_IDXW = $clog2(BHT_ENTRIES);

    logic [1:0]          r_bht [BHT_ENTRIES];
    logic [BHT_IDXW-1:0] w_rd_idx;
    logic [BHT_IDXW-1:0] w_wr_idx;
    logic                w_bht_upd;
    logic                w_unused_ok;

    assign w_rd_idx  = bus.ifu_pc[BHT_IDXW+1:2];
    assign w_wr_idx  = r_pc[BHT_IDXW+1:2];
    assign w_bht_upd = w_resolve && r_is_br && !r_is_jal && !r_is_jalr && !w_illegal;

    // Counter training at the resolve edge of each legal B-type op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_upd) begin
            if (w_taken && (r_bht[w_wr_idx] != 2'b11)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'd1;
            end else if (!w_taken && (r_bht[w_wr_idx] != 2'b00)) begin
                r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'd1;
            end
        end
    end

    assign bus.ifu_pred_taken = r_bht[w_rd_idx][1];
    assign w_id_pred          = bus.id_pred_taken;
    assign w_unused_ok        = ^{bus.ifu_pc[XLEN-1:BHT_IDXW+2], bus.ifu_pc[1:0]};
`else
    logic w_unused_ok;

    // Static predict-not-taken: fetch and the carried prediction agree on 0.
    assign bus.ifu_pred_taken = 1'b0;
    assign w_id_pred          = 1'b0;
    assign w_unused_ok        = ^{bus.ifu_pc, bus.id_pred_taken, BHT_ENTRIES[0]};
`endif

    assign bus.id_ready       = w_ready;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = (r_state == S_FLUSH);
    assign bus.illegal_br     = r_illegal;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed bench for branch_resolve_ctrl with a
// transaction-level reference model and per-cycle output comparison.
// Optional feature macro: BRANCH_BHT_EN (adds prediction-table tests).
module tb_branch_resolve_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg_state;
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    branch_resolve_if #(.XLEN(32)) bus ();

    branch_resolve_ctrl #(
        .XLEN(32), .FLUSH_CYCLES(FLUSH_CYCLES), .BHT_ENTRIES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        pred;
    } op_t;

    op_t         m_slot;
    bit          m_slot_valid = 0;
    int          m_flush_left = 0;
    bit          m_rv = 0;
    logic [31:0] m_rpc = 32'h0;
    bit          m_ill = 0;
    int          m_bht [64];

    // RV32I control-transfer semantics.
    function automatic void model_resolve(input op_t o, output bit taken,
                                          output logic [31:0] tgt, output bit ill);
        taken = 0;
        ill   = 0;
        tgt   = o.pc + o.imm;
        if (o.jalr) begin
            taken = 1;
            tgt   = (o.rs1 + o.imm) & 32'hFFFF_FFFE;
        end else if (o.jal) begin
            taken = 1;
        end else if (o.br) begin
            case (o.f3)
                3'd0: taken = (o.rs1 == o.rs2);
                3'd1: taken = (o.rs1 != o.rs2);
                3'd4: taken = ($signed(o.rs1) <  $signed(o.rs2));
                3'd5: taken = ($signed(o.rs1) >= $signed(o.rs2));
                3'd6: taken = (o.rs1 <  o.rs2);
                3'd7: taken = (o.rs1 >= o.rs2);
                3'd2, 3'd3: ill = 1;
            endcase
        end
    endfunction

    function automatic bit model_ready();
        if (m_flush_left > 0) return 0;
        if (!m_slot_valid) return 1;
        return !bus.ex_stall;
    endfunction

    function automatic bit model_ifu_pred();
`ifdef BRANCH_BHT_EN
        return m_bht[(bus.ifu_pc >> 2) % 64] >= 2;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one clock.
    always @(posedge clk or negedge rst_n) begin
        bit          cap;
        bit          tk;
        bit          il;
        logic [31:0] tg;
        op_t         in_op;
        if (!rst_n) begin
            m_slot_valid = 0;
            m_flush_left = 0;
            m_rv  = 0;
            m_rpc = 32'h0;
            m_ill = 0;
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
        end else begin
            cap = bus.id_valid && model_ready();
            in_op.br   = bus.id_is_br;
            in_op.jal  = bus.id_is_jal;
            in_op.jalr = bus.id_is_jalr;
            in_op.f3   = bus.id_funct3;
            in_op.pc   = bus.id_pc;
            in_op.imm  = bus.id_imm;
            in_op.rs1  = bus.id_rs1_dat;
            in_op.rs2  = bus.id_rs2_dat;
`ifdef BRANCH_BHT_EN
            in_op.pred = bus.id_pred_taken;
`else
            in_op.pred = 1'b0;
`endif
            m_rv  = 0;
            m_ill = 0;
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_slot_valid && !bus.ex_stall) begin
                model_resolve(m_slot, tk, tg, il);
                m_ill = il;
                if (m_slot.br && !m_slot.jal && !m_slot.jalr && !il) begin
                    int k;
                    k = (m_slot.pc >> 2) % 64;
                    if (tk && m_bht[k] < 3) m_bht[k]++;
                    if (!tk && m_bht[k] > 0) m_bht[k]--;
                end
                if ((tk != m_slot.pred) || m_slot.jalr) begin
                    m_rv  = 1;
                    m_rpc = tk ? tg : (m_slot.pc + 32'd4);
                    m_flush_left = FLUSH_CYCLES;
                    m_slot_valid = 0;
                end else begin
                    m_slot_valid = cap;
                    if (cap) m_slot = in_op;
                end
            end else if (!m_slot_valid) begin
                m_slot_valid = cap;
                if (cap) m_slot = in_op;
            end
        end
    end

    // Per-cycle comparison, mid-cycle while everything is stable.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp id_ready", 32'(bus.id_ready), 32'(model_ready()));
            check("cmp redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
            if (m_rv) check("cmp redirect_pc", bus.redirect_pc, m_rpc);
            check("cmp flush", 32'(bus.flush), 32'(m_flush_left > 0));
            check("cmp illegal_br", 32'(bus.illegal_br), 32'(m_ill));
            check("cmp ifu_pred_taken", 32'(bus.ifu_pred_taken), 32'(model_ifu_pred()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_op(input logic br, input logic jal, input logic jalr,
                            input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic pred);
        bus.id_valid      = 1'b1;
        bus.id_is_br      = br;
        bus.id_is_jal     = jal;
        bus.id_is_jalr    = jalr;
        bus.id_funct3     = f3;
        bus.id_pc         = pc;
        bus.id_imm        = imm;
        bus.id_rs1_dat    = rs1;
        bus.id_rs2_dat    = rs2;
        bus.id_pred_taken = pred;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the capture edge.
    task automatic send_op(input string name, input logic br, input logic jal,
                           input logic jalr, input logic [2:0] f3,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic pred, output int cap_cyc);
        bit acc;
        acc = 0;
        drive_op(br, jal, jalr, f3, pc, imm, rs1, rs2, pred);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = bus.id_ready;
            @(posedge clk);
            #1;
        end
        cap_cyc = cyc;
        bus.id_valid = 1'b0;
        check({name, " accepted"}, 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bus.id_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) for a redirect pulse; returns at that negedge.
    task automatic expect_redirect(input string name, input logic [31:0] pc_lit);
        bit seen;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (bus.redirect_valid) seen = 1;
        end
        check({name, " redirect seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " redirect_pc"}, bus.redirect_pc, pc_lit);
            check({name, " model redirect_pc"}, m_rpc, pc_lit);
        end
    endtask

    // Counts redirect and illegal pulses over n cycles, then realigns.
    task automatic watch(input int n, output int rcnt, output int icnt);
        rcnt = 0;
        icnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.redirect_valid) rcnt++;
            if (bus.illegal_br) icnt++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int c1;
        int c2;
        int rc;
        int ic;
        bus.id_valid = 1'b0;
        bus.id_is_br = 1'b0;
        bus.id_is_jal = 1'b0;
        bus.id_is_jalr = 1'b0;
        bus.id_funct3 = 3'd0;
        bus.id_pc = 32'h0;
        bus.id_imm = 32'h0;
        bus.id_rs1_dat = 32'h0;
        bus.id_rs2_dat = 32'h0;
        bus.id_pred_taken = 1'b0;
        bus.ex_stall = 1'b0;
        bus.ifu_pc = 32'h0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("reset id_ready", 32'(bus.id_ready), 32'd1);
        check("reset redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("reset flush", 32'(bus.flush), 32'd0);
        check("reset illegal_br", 32'(bus.illegal_br), 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;

        // BEQ taken, predicted not-taken: redirect, 2-cycle flush window
        send_op("beq", 1, 0, 0, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 0, c1);
        expect_redirect("beq", 32'h120);
        check("beq flush c1", 32'(bus.flush), 32'd1);
        check("beq ready c1", 32'(bus.id_ready), 32'd0);
        @(negedge clk);
        check("beq flush c2", 32'(bus.flush), 32'd1);
        check("beq ready c2", 32'(bus.id_ready), 32'd0);
        @(negedge clk);
        check("beq flush end", 32'(bus.flush), 32'd0);
        check("beq ready end", 32'(bus.id_ready), 32'd1);
        @(posedge clk);
        #1;

        // Signed vs unsigned with rs1=-1, rs2=1
        send_op("blt", 1, 0, 0, 3'd4, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, c1);
        expect_redirect("blt", 32'h210);
        idle(4);
        send_op("bltu", 1, 0, 0, 3'd6, 32'h240, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, c1);
        watch(3, rc, ic);
        check("bltu no redirect", 32'(rc), 32'd0);
        send_op("bgeu", 1, 0, 0, 3'd7, 32'h300, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 0, c1);
        expect_redirect("bgeu", 32'h2F8);
        idle(4);

        // JALR target clears bit 0; JAL wraps around
        send_op("jalr", 0, 0, 1, 3'd0, 32'h380, 32'h0, 32'h2003, 32'h0, 0, c1);
        expect_redirect("jalr", 32'h2002);
        idle(4);
        send_op("jal", 0, 1, 0, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 0, c1);
        expect_redirect("jal wrap", 32'h10);
        idle(4);

        // Back-to-back not-taken BNE ops
        send_op("bne0", 1, 0, 0, 3'd1, 32'h400, 32'h40, 32'd9, 32'd9, 0, c1);
        send_op("bne1", 1, 0, 0, 3'd1, 32'h404, 32'h40, 32'd9, 32'd9, 0, c2);
        check("b2b capture spacing", 32'(c2 - c1), 32'd1);
        watch(3, rc, ic);
        check("b2b no redirect", 32'(rc), 32'd0);

        // Stall freezes a taken BEQ; younger JAL is accepted then dropped
        send_op("stall beq", 1, 0, 0, 3'd0, 32'h500, 32'h40, 32'd3, 32'd3, 0, c1);
        bus.ex_stall = 1'b1;
        drive_op(0, 1, 0, 3'd0, 32'h600, 32'h100, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall id_ready", 32'(bus.id_ready), 32'd0);
            check("stall redirect_valid", 32'(bus.redirect_valid), 32'd0);
            check("stall flush", 32'(bus.flush), 32'd0);
            check("stall state", 32'(dbg_state), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.ex_stall = 1'b0;
        @(negedge clk);
        check("unstall id_ready", 32'(bus.id_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.id_valid = 1'b0;
        expect_redirect("stall beq", 32'h540);
        idle(5);

        // Illegal funct3
        send_op("illegal", 1, 0, 0, 3'd2, 32'h700, 32'h40, 32'd1, 32'd1, 0, c1);
        watch(3, rc, ic);
        check("illegal no redirect", 32'(rc), 32'd0);
        check("illegal pulse count", 32'(ic), 32'd1);

        // Reset asserted during FLUSH
        send_op("rst jal", 0, 1, 0, 3'd0, 32'h800, 32'h40, 32'h0, 32'h0, 0, c1);
        expect_redirect("rst jal", 32'h840);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid-flush reset flush", 32'(bus.flush), 32'd0);
        check("mid-flush reset state", 32'(dbg_state), 32'd0);
        check("mid-flush reset redirect", 32'(bus.redirect_valid), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        idle(3);

`ifdef BRANCH_BHT_EN
        // Prediction table training at pc 0x40
        bus.ifu_pc = 32'h40;
        @(negedge clk);
        check("bht initial pred", 32'(bus.ifu_pred_taken), 32'd0);
        @(posedge clk);
        #1;
        send_op("bht t1", 1, 0, 0, 3'd0, 32'h40, 32'h10, 32'd7, 32'd7, 0, c1);
        expect_redirect("bht t1", 32'h50);
        check("bht pred after 1", 32'(bus.ifu_pred_taken), 32'd1);
        idle(4);
        send_op("bht t2", 1, 0, 0, 3'd0, 32'h40, 32'h10, 32'd7, 32'd7, 0, c1);
        expect_redirect("bht t2", 32'h50);
        check("bht pred after 2", 32'(bus.ifu_pred_taken), 32'd1);
        idle(4);
        send_op("bht t3", 1, 0, 0, 3'd0, 32'h40, 32'h10, 32'd7, 32'd7, 1, c1);
        watch(3, rc, ic);
        check("bht t3 no redirect", 32'(rc), 32'd0);
        check("bht pred after 3", 32'(bus.ifu_pred_taken), 32'd1);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
